// File: rtl/tone_pkg.sv
// Shared constants, width helpers and channel-state layout for the multi-channel tone generator.
package tone_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned DIV_W_DEF  = 20;

  // Mix level must represent 0..n inclusive.
  function automatic int unsigned mix_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned ch_idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [DIV_W_DEF-1:0] active_div;
    logic [DIV_W_DEF-1:0] pend_div;
    logic                 pend;
    logic [DIV_W_DEF-1:0] count;
    logic                 tone;
  } ch_state_t;

endpackage

// File: rtl/tone_ch.sv
// One tone channel: half-period down-counter, pending divider and square-wave toggle.
// TONE_GEN_DUTY_EN adds a per-write duty code that stretches the low half-period.
module tone_ch
  import tone_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef TONE_GEN_DUTY_EN
  input  logic [1:0]       wr_duty,
`endif
  input  logic             sync_clr,
  output logic             tone,
  output logic             pend
);

`ifdef TONE_GEN_DUTY_EN
  localparam int unsigned CNT_W = DIV_W + 3;
`else
  localparam int unsigned CNT_W = DIV_W;
`endif

  typedef struct packed {
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend;
    logic [CNT_W-1:0] count;
    logic             tone;
  } state_t;

  state_t st_q, st_d;

  logic [DIV_W-1:0] next_div;
  logic [1:0]       wr_duty_v;
  logic [1:0]       next_duty;
  logic             running;
  logic             wrap;

  // Low half lasts (div+1) << duty clocks; with duty 0 this reduces to div.
  function automatic logic [CNT_W-1:0] low_reload(logic [DIV_W-1:0] div, logic [1:0] duty);
    logic [CNT_W:0] len;
    len = (CNT_W+1)'(div) + (CNT_W+1)'(1);
    len = len << duty;
    return CNT_W'(len - (CNT_W+1)'(1));
  endfunction

  assign running  = (st_q.active_div != '0);
  assign wrap     = running && (st_q.count == '0);
  assign next_div = st_q.pend ? st_q.pend_div : st_q.active_div;

`ifdef TONE_GEN_DUTY_EN
  logic [1:0] active_duty_q, active_duty_d, pend_duty_q, pend_duty_d;

  assign wr_duty_v = wr_duty;
  assign next_duty = st_q.pend ? pend_duty_q : active_duty_q;

  always_comb begin
    active_duty_d = active_duty_q;
    pend_duty_d   = pend_duty_q;
    if (running && (sync_clr || wrap)) begin
      active_duty_d = next_duty;
    end else if (!running && wr && (wr_div != '0)) begin
      active_duty_d = wr_duty;
    end
    if (running && wr) begin
      pend_duty_d = wr_duty;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      active_duty_q <= 2'b00;
      pend_duty_q   <= 2'b00;
    end else begin
      active_duty_q <= active_duty_d;
      pend_duty_q   <= pend_duty_d;
    end
  end
`else
  assign wr_duty_v = 2'b00;
  assign next_duty = 2'b00;
`endif

  always_comb begin
    st_d = st_q;
    if (running && sync_clr) begin
      // Clear wins over a wrap; a pending divider is promoted before restarting the low half.
      st_d.active_div = next_div;
      st_d.pend       = 1'b0;
      st_d.tone       = 1'b0;
      st_d.count      = (next_div == '0) ? '0 : low_reload(next_div, next_duty);
    end else if (wrap) begin
      st_d.active_div = next_div;
      st_d.pend       = 1'b0;
      if (next_div == '0) begin
        st_d.tone  = 1'b0;
        st_d.count = '0;
      end else begin
        st_d.tone  = ~st_q.tone;
        st_d.count = st_q.tone ? low_reload(next_div, next_duty) : CNT_W'(next_div);
      end
    end else if (running) begin
      st_d.count = st_q.count - CNT_W'(1);
    end else if (wr && (wr_div != '0)) begin
      st_d.active_div = wr_div;
      st_d.count      = low_reload(wr_div, wr_duty_v);
      st_d.tone       = 1'b0;
    end
    // A write to a running channel always lands in the pending slot, even on a wrap or clear.
    if (running && wr) begin
      st_d.pend_div = wr_div;
      st_d.pend     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign tone = st_q.tone;
  assign pend = st_q.pend;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave pitch generator: write decode, channel array and registered mix level.
// Optional macro TONE_GEN_DUTY_EN adds the wr_duty input for non-50% duty cycles.
module tone_gen_multi
  import tone_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  localparam int unsigned MIX_W = mix_width(NUM_CH),
  localparam int unsigned CH_W  = ch_idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
`ifdef TONE_GEN_DUTY_EN
  input  logic [1:0]        wr_duty,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tone_out,
  output logic [NUM_CH-1:0] pend,
  output logic [MIX_W-1:0]  mix
);

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] tone;
  logic [MIX_W-1:0]  mix_d, mix_q;

  // Out-of-range indices match no channel, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

    tone_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk     (clk),
      .reset_  (reset_),
      .wr      (wr_hit[i]),
      .wr_div  (wr_div),
`ifdef TONE_GEN_DUTY_EN
      .wr_duty (wr_duty),
`endif
      .sync_clr(sync_clr),
      .tone    (tone[i]),
      .pend    (pend[i])
    );
  end

  assign tone_out = tone & ch_en;

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_d = mix_d + MIX_W'(tone_out[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix = mix_q;

endmodule
